// File: rtl/telemetry_rx_pkg.sv
// Shared telemetry-link definitions: framing bytes, receiver FSM encodings and
// the decoded packet record. The transmitter imports the same package.
package telem_pkg;

  localparam logic [7:0]  HDR1_BYTE = 8'hAA;
  localparam logic [7:0]  HDR2_BYTE = 8'h55;
  localparam int unsigned PKT_BYTES = 8;

  typedef enum logic [$clog2(PKT_BYTES)-1:0] {
    HDR1, HDR2, BH, BL, CH, CL, TH, TL
  } pkt_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } bit_state_t;

  typedef struct packed {
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
  } telem_t;

endpackage

// File: rtl/telemetry_rx_if.sv
// Decoded telemetry output bundle: three readings plus their strobe and error pulses.
interface telemetry_rx_if;

  logic [11:0] batt;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;
  logic        pkt_vld;
  logic        frame_err;
  logic        fmt_err;

  modport master (output batt, avg_curr, avg_torque, pkt_vld, frame_err, fmt_err);
  modport slave  (input  batt, avg_curr, avg_torque, pkt_vld, frame_err, fmt_err);

endinterface

// File: rtl/telemetry_rx_uart_rx_byte.sv
// UART byte receiver, 8N1, LSB first: RX synchroniser, mid-bit sampling,
// byte_rdy on good stop bit, frame_err when the stop bit samples low.
module uart_rx_byte
  import telem_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned    CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0]  BIT_END  = CW'(BAUD_DIV - 1);

    logic          rx_s1, rx_s2, rx_s3;
    bit_state_t    state, state_nx;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          start_edge, half_done, bit_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_edge = rx_s3 & ~rx_s2;
    assign half_done  = (baud_cnt == HALF_END);
    assign bit_done   = (baud_cnt == BIT_END);

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RX_IDLE:  if (start_edge) state_nx = RX_START;
            RX_START: if (half_done)  state_nx = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_done && bit_cnt == 3'd7) state_nx = RX_STOP;
            RX_STOP:  if (bit_done) state_nx = RX_IDLE;
            default:  state_nx = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_rdy  = (state == RX_STOP) && bit_done &&  rx_s2;
        frame_err = (state == RX_STOP) && bit_done && !rx_s2;
        rx_byte   = shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            if (state == RX_IDLE || (state == RX_START && half_done) || bit_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state == RX_IDLE)
                bit_cnt <= '0;
            else if (state == RX_DATA && bit_done) begin
                bit_cnt <= bit_cnt + 1'b1;
                shift   <= {rx_s2, shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry link receiver: packet framing FSM over uart_rx_byte, shadow
// registers for atomic update of battery / current / torque, inter-byte timeout.
module telemetry_rx
  import telem_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned BYTE_TO  = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RX,
    telemetry_rx_if.master  tif
);

    localparam int unsigned   TW      = $clog2(BYTE_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BYTE_TO - 1);

    logic        byte_rdy, rx_ferr;
    logic [7:0]  rx_byte;
    pkt_state_t  state, state_nx;
    logic [11:0] sh_batt, sh_curr;
    logic [3:0]  sh_tq_hi;
    logic [TW-1:0] to_cnt;
    logic        nib_state, nib_err, timeout, latch, fmt_err_d;
    telem_t      pkt_next;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .byte_rdy  (byte_rdy),
        .rx_byte   (rx_byte),
        .frame_err (rx_ferr)
    );

    assign nib_state = (state == BH) || (state == CH) || (state == TH);
    assign nib_err   = (rx_byte[7:4] != 4'h0);
    // to_cnt restarts at 1 so the registered fmt_err lands exactly BYTE_TO clocks after byte_rdy
    assign timeout   = (state != HDR1) && !byte_rdy && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= HDR1;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (rx_ferr || timeout)
            state_nx = HDR1;
        else if (byte_rdy) begin
            case (state)
                HDR1: if (rx_byte == HDR1_BYTE) state_nx = HDR2;
                HDR2: begin
                    if      (rx_byte == HDR2_BYTE) state_nx = BH;
                    else if (rx_byte == HDR1_BYTE) state_nx = HDR2;
                    else                           state_nx = HDR1;
                end
                BH:      state_nx = nib_err ? HDR1 : BL;
                BL:      state_nx = CH;
                CH:      state_nx = nib_err ? HDR1 : CL;
                CL:      state_nx = TH;
                TH:      state_nx = nib_err ? HDR1 : TL;
                TL:      state_nx = HDR1;
                default: state_nx = HDR1;
            endcase
        end
    end

    always_comb begin
        latch     = byte_rdy && (state == TL);
        fmt_err_d = !rx_ferr && (timeout || (byte_rdy && nib_state && nib_err));
        pkt_next  = '{batt: sh_batt, curr: sh_curr, torque: {sh_tq_hi, rx_byte}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_batt        <= '0;
            sh_curr        <= '0;
            sh_tq_hi       <= '0;
            to_cnt         <= TW'(1);
            tif.batt       <= '0;
            tif.avg_curr   <= '0;
            tif.avg_torque <= '0;
            tif.pkt_vld    <= 1'b0;
            tif.frame_err  <= 1'b0;
            tif.fmt_err    <= 1'b0;
        end else begin
            to_cnt <= (byte_rdy || state == HDR1) ? TW'(1) : to_cnt + 1'b1;

            if (rx_ferr || fmt_err_d) begin
                sh_batt  <= '0;
                sh_curr  <= '0;
                sh_tq_hi <= '0;
            end else if (byte_rdy) begin
                case (state)
                    BH:      sh_batt[11:8] <= rx_byte[3:0];
                    BL:      sh_batt[7:0]  <= rx_byte;
                    CH:      sh_curr[11:8] <= rx_byte[3:0];
                    CL:      sh_curr[7:0]  <= rx_byte;
                    TH:      sh_tq_hi      <= rx_byte[3:0];
                    default: ;
                endcase
            end

            if (latch) begin
                tif.batt       <= pkt_next.batt;
                tif.avg_curr   <= pkt_next.curr;
                tif.avg_torque <= pkt_next.torque;
            end
            tif.pkt_vld   <= latch;
            tif.frame_err <= rx_ferr;
            tif.fmt_err   <= fmt_err_d;
        end
    end

endmodule
